// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 8;
  localparam int unsigned OPW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // addr[17:16] value that selects the UART/IO window
  localparam logic [1:0] IO_REGION = 2'b11;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    op;
  } req_t;

  // Index of the final byte of a transfer (N-1); the unused size code behaves as a word
  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 2'd0;
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_unit.sv
// Combinational byte-lane helper: store byte select, load byte merge and load extension.
module mem_byte_unit
  import mem_ctrl_pkg::*;
(
  input  logic [DW-1:0] data,
  input  logic [1:0]    wr_idx,
  input  logic [DW-1:0] result,
  input  logic [BW-1:0] din,
  input  logic [1:0]    rd_idx,
  input  logic [2:0]    op,
  output logic [BW-1:0] store_byte,
  output logic [DW-1:0] merged,
  output logic [DW-1:0] load_val
);

  always_comb begin
    store_byte = data[{wr_idx, 3'b000} +: BW];
    merged     = result;
    merged[{rd_idx, 3'b000} +: BW] = din;
    // op[2] selects zero extension for sub-word loads
    unique case (op[1:0])
      SZ_BYTE: load_val = op[2] ? {24'd0, merged[7:0]}  : {{24{merged[7]}}, merged[7:0]};
      SZ_HALF: load_val = op[2] ? {16'd0, merged[15:0]} : {{16{merged[15]}}, merged[15:0]};
      default: load_val = merged;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial load/store engine between the LSB and an 8-bit synchronous RAM.
// Optional: define MEM_IO_STALL_EN to hold stores to the IO window while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           clear_flag,
  input  logic           lsb_valid,
  input  logic [AW-1:0]  lsb_addr,
  input  logic [DW-1:0]  lsb_data,
  input  logic           lsb_load_or_store,
  input  logic [OPW-1:0] lsb_op,
  output logic           mem_ready,
  output logic [DW-1:0]  mem_val,
  input  logic [BW-1:0]  mem_din,
  output logic [BW-1:0]  mem_dout,
  output logic [AW-1:0]  mem_a,
  output logic           mem_wr,
  input  logic           io_buffer_full
);

  state_t        state, state_n;
  logic [1:0]    cnt, cnt_n;
  req_t          req, req_n;
  logic          primed, primed_n;
  logic          flushed, flushed_n;
  logic [AW-1:0] a_r, a_n;
  logic [BW-1:0] dout_r, dout_n;
  logic          wr_r, wr_n;
  logic          ready_r, ready_n;
  logic [DW-1:0] val_r, val_n;
  logic [DW-1:0] res_r, res_n;
  logic [1:0]    last;
  logic          stall;
  logic [BW-1:0] store_byte;
  logic [DW-1:0] merged, load_val;
  logic          unused_op;

  assign last      = last_idx(req.op[1:0]);
  assign unused_op = lsb_op[3];

`ifdef MEM_IO_STALL_EN
  assign stall = (state == ST_WRITE) && (req.addr[17:16] == IO_REGION) && io_buffer_full;
`else
  logic unused_io;
  assign stall     = 1'b0;
  assign unused_io = io_buffer_full & (req.addr[17:16] == IO_REGION);
`endif

  mem_byte_unit u_byte (
    .data       (req.data),
    .wr_idx     (cnt + 2'd1),
    .result     (res_r),
    .din        (mem_din),
    .rd_idx     (cnt),
    .op         (req.op),
    .store_byte (store_byte),
    .merged     (merged),
    .load_val   (load_val)
  );

  // Register bank; rdy_in low freezes everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req     <= '0;
      primed  <= 1'b0;
      flushed <= 1'b0;
      a_r     <= '0;
      dout_r  <= '0;
      wr_r    <= 1'b0;
      ready_r <= 1'b0;
      val_r   <= '0;
      res_r   <= '0;
    end else if (rdy_in) begin
      state   <= state_n;
      cnt     <= cnt_n;
      req     <= req_n;
      primed  <= primed_n;
      flushed <= flushed_n;
      a_r     <= a_n;
      dout_r  <= dout_n;
      wr_r    <= wr_n;
      ready_r <= ready_n;
      val_r   <= val_n;
      res_r   <= res_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_n     = req;
    primed_n  = primed;
    flushed_n = flushed;
    a_n       = a_r;
    dout_n    = dout_r;
    wr_n      = wr_r;
    ready_n   = 1'b0;
    val_n     = val_r;
    res_n     = res_r;
    unique case (state)
      ST_IDLE: begin
        if (lsb_valid && !clear_flag) begin
          req_n.addr = lsb_addr;
          req_n.data = lsb_data;
          req_n.op   = lsb_op[2:0];
          a_n        = lsb_addr;
          cnt_n      = 2'd0;
          primed_n   = 1'b0;
          flushed_n  = 1'b0;
          res_n      = '0;
          if (lsb_load_or_store) begin
            state_n = ST_WRITE;
            wr_n    = 1'b1;
            dout_n  = lsb_data[7:0];
          end else begin
            state_n = ST_READ;
          end
        end
      end
      // RAM returns a byte one cycle after its address, so capture trails issue by one
      ST_READ: begin
        if (clear_flag) begin
          state_n = ST_IDLE;
        end else if (!primed) begin
          primed_n = 1'b1;
          if (last != 2'd0) a_n = req.addr + AW'(1);
        end else begin
          res_n = merged;
          if (cnt == last) begin
            state_n = ST_DONE;
            ready_n = 1'b1;
            val_n   = load_val;
          end else begin
            cnt_n = cnt + 2'd1;
            if (({1'b0, cnt} + 3'd2) <= {1'b0, last}) a_n = req.addr + AW'(cnt) + AW'(2);
          end
        end
      end
      ST_WRITE: begin
        if (clear_flag) flushed_n = 1'b1;
        if (!stall) begin
          if (cnt == last) begin
            state_n = ST_DONE;
            wr_n    = 1'b0;
            ready_n = !(flushed || clear_flag);
            val_n   = '0;
          end else begin
            cnt_n  = cnt + 2'd1;
            a_n    = req.addr + AW'(cnt) + AW'(1);
            dout_n = store_byte;
            wr_n   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A flush arriving during the completion cycle still cancels the pulse
  assign mem_ready = ready_r & ~clear_flag;
  assign mem_wr    = wr_r & rdy_in & ~stall;
  assign mem_val   = val_r;
  assign mem_a     = a_r;
  assign mem_dout  = dout_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl; byte RAM and expected results are modelled from the request rules.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_flag, lsb_valid, lsb_load_or_store, io_buffer_full;
  logic [31:0] lsb_addr, lsb_data;
  logic [3:0]  lsb_op;
  logic [7:0]  mem_din;
  logic        mem_ready, mem_wr;
  logic [31:0] mem_val, mem_a;
  logic [7:0]  mem_dout;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram [logic [31:0]];

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .clear_flag        (clear_flag),
    .lsb_valid         (lsb_valid),
    .lsb_addr          (lsb_addr),
    .lsb_data          (lsb_data),
    .lsb_load_or_store (lsb_load_or_store),
    .lsb_op            (lsb_op),
    .mem_ready         (mem_ready),
    .mem_val           (mem_val),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full)
  );

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'((a * 32'd7) ^ (a >> 8) ^ 32'h5A);
  endfunction

  // Synchronous-read RAM: the byte for an address appears one cycle later
  always @(posedge clk_in) mem_din <= ram_rd(mem_a);

  function automatic int nbytes(input logic [3:0] op);
    return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [3:0] op);
    longint unsigned v = 0;
    int n = nbytes(op);
    for (int i = 0; i < n; i++) v = v | (64'(ram_rd(addr + 32'(i))) << (8 * i));
    if (!op[2] && n < 4 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1)
      v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [3:0] op, input string nm);
    int n = nbytes(op);
    logic [31:0] exp_val = model_load(addr, op);
    lsb_valid = 1'b1; lsb_load_or_store = 1'b0; lsb_addr = addr; lsb_op = op; lsb_data = $urandom;
    tick();
    for (int c = 1; c <= n + 1; c++) begin
      #1;
      checks++;
      if ({mem_ready, mem_wr} !== 2'b00) begin
        failures++; $display("FAIL %s early ready/wr cyc=%0d got=%b exp=00", nm, c, {mem_ready, mem_wr});
      end
      if (c <= n) begin
        checks++;
        if (mem_a !== addr + 32'(c - 1)) begin
          failures++; $display("FAIL %s read addr cyc=%0d got=%h exp=%h", nm, c, mem_a, addr + 32'(c - 1));
        end
      end
      tick();
    end
    #1;
    checks++;
    if ({mem_ready, mem_val} !== {1'b1, exp_val}) begin
      failures++; $display("FAIL %s result got ready=%b val=%h exp ready=1 val=%h", nm, mem_ready, mem_val, exp_val);
    end
    lsb_valid = 1'b0;
    tick(); #1;
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++; $display("FAIL %s ready after done got=%b exp=0", nm, mem_ready);
    end
  endtask

  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] op, input string nm);
    int n = nbytes(op);
    lsb_valid = 1'b1; lsb_load_or_store = 1'b1; lsb_addr = addr; lsb_data = data; lsb_op = op;
    tick();
    for (int k = 0; k < n; k++) begin
      #1;
      checks++;
      if ({mem_ready, mem_wr, mem_a, mem_dout} !== {1'b0, 1'b1, addr + 32'(k), 8'(data >> (8 * k))}) begin
        failures++; $display("FAIL %s write byte %0d got rdy=%b wr=%b a=%h d=%h exp rdy=0 wr=1 a=%h d=%h",
                             nm, k, mem_ready, mem_wr, mem_a, mem_dout, addr + 32'(k), 8'(data >> (8 * k)));
      end
      tick();
    end
    #1;
    checks++;
    if ({mem_ready, mem_wr, mem_val} !== {1'b1, 1'b0, 32'd0}) begin
      failures++; $display("FAIL %s store done got rdy=%b wr=%b val=%h exp rdy=1 wr=0 val=0", nm, mem_ready, mem_wr, mem_val);
    end
    lsb_valid = 1'b0;
    tick(); #1;
    checks++;
    if ({mem_ready, mem_wr} !== 2'b00) begin
      failures++; $display("FAIL %s idle after store got=%b exp=00", nm, {mem_ready, mem_wr});
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({mem_ready, mem_wr, mem_val, mem_a, mem_dout} !== 74'd0) begin
      failures++; $display("FAIL reset outputs got rdy=%b wr=%b val=%h a=%h d=%h exp all 0", mem_ready, mem_wr, mem_val, mem_a, mem_dout);
    end
    repeat (2) @(posedge clk_in);
    #3 rst_in = 1'b0;
    tick();
  endtask

  task automatic test_load_sign();
    run_load(32'h100, 4'h0, "lb_0x100");
    run_load(32'h100, 4'h4, "lbu_0x100");
    run_load(32'h101, 4'h1, "lh_signed");
    run_load(32'h101, 4'h5, "lhu");
  endtask

  task automatic test_load_word();
    run_load(32'h200, 4'h2, "lw_0x200");
  endtask

  task automatic test_store_wrap();
    run_store(32'hFFFF_FFFF, 32'hABCD_1234, 4'h1, "sh_wrap");
  endtask

  task automatic test_clear_read();
    lsb_valid = 1'b1; lsb_load_or_store = 1'b0; lsb_addr = 32'h200; lsb_op = 4'h2;
    tick();
    #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL clear_read c1 ready got=%b exp=0", mem_ready); end
    lsb_valid = 1'b0;
    tick();
    clear_flag = 1'b1; #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL clear_read c2 ready got=%b exp=0", mem_ready); end
    tick();
    clear_flag = 1'b0; #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL clear_read c3 ready got=%b exp=0", mem_ready); end
    run_load(32'h100, 4'h0, "lb_after_flush");
  endtask

  task automatic test_clear_write();
    lsb_valid = 1'b1; lsb_load_or_store = 1'b1; lsb_addr = 32'h500; lsb_data = 32'hCAFE_F00D; lsb_op = 4'h2;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) clear_flag = 1'b1;
      #1;
      checks++;
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h500 + 32'(k), 8'(32'hCAFE_F00D >> (8 * k))}) begin
        failures++; $display("FAIL clear_write byte %0d got wr=%b a=%h d=%h", k, mem_wr, mem_a, mem_dout);
      end
      lsb_valid = 1'b0;
      tick();
      clear_flag = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({mem_ready, mem_wr} !== 2'b00) begin
        failures++; $display("FAIL clear_write tail cyc=%0d got=%b exp=00", c, {mem_ready, mem_wr});
      end
      tick();
    end
  endtask

  task automatic test_clear_done();
    lsb_valid = 1'b1; lsb_load_or_store = 1'b0; lsb_addr = 32'h100; lsb_op = 4'h0;
    tick(); tick(); tick();
    clear_flag = 1'b1; #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL clear_done ready got=%b exp=0", mem_ready); end
    lsb_valid = 1'b0;
    tick();
    clear_flag = 1'b0; #1;
    checks++;
    if (mem_ready !== 1'b0) begin failures++; $display("FAIL clear_done idle ready got=%b exp=0", mem_ready); end
  endtask

  task automatic test_clear_idle();
    clear_flag = 1'b1; lsb_valid = 1'b1; lsb_load_or_store = 1'b1; lsb_addr = 32'h800; lsb_data = 32'hFF; lsb_op = 4'h0;
    tick();
    clear_flag = 1'b0; lsb_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({mem_wr, mem_ready} !== 2'b00) begin
        failures++; $display("FAIL clear_idle cyc=%0d got=%b exp=00", c, {mem_wr, mem_ready});
      end
      tick();
    end
  endtask

  task automatic test_rdy_stall();
    lsb_valid = 1'b1; lsb_load_or_store = 1'b1; lsb_addr = 32'h600; lsb_data = 32'h0102_0304; lsb_op = 4'h2;
    tick(); #1;
    checks++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h600, 8'h04}) begin
      failures++; $display("FAIL rdy_stall byte0 got wr=%b a=%h d=%h", mem_wr, mem_a, mem_dout);
    end
    tick();
    rdy_in = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({mem_wr, mem_a} !== {1'b0, 32'h601}) begin
        failures++; $display("FAIL rdy_stall hold cyc=%0d got wr=%b a=%h exp wr=0 a=601", c, mem_wr, mem_a);
      end
      tick();
    end
    rdy_in = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      checks++;
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h600 + 32'(k), 8'(32'h0102_0304 >> (8 * k))}) begin
        failures++; $display("FAIL rdy_stall byte%0d got wr=%b a=%h d=%h", k, mem_wr, mem_a, mem_dout);
      end
      tick();
    end
    #1;
    checks++;
    if ({mem_ready, mem_wr} !== 2'b10) begin failures++; $display("FAIL rdy_stall done got=%b exp=10", {mem_ready, mem_wr}); end
    lsb_valid = 1'b0;
    tick();
  endtask

  task automatic test_io();
`ifdef MEM_IO_STALL_EN
    io_buffer_full = 1'b1;
    lsb_valid = 1'b1; lsb_load_or_store = 1'b1; lsb_addr = 32'h0003_0000; lsb_data = 32'h5A; lsb_op = 4'h0;
    tick();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({mem_wr, mem_ready} !== 2'b00) begin failures++; $display("FAIL io_stall cyc=%0d got=%b exp=00", c, {mem_wr, mem_ready}); end
      tick();
    end
    io_buffer_full = 1'b0; #1;
    checks++;
    if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h0003_0000, 8'h5A}) begin
      failures++; $display("FAIL io_stall write got wr=%b a=%h d=%h", mem_wr, mem_a, mem_dout);
    end
    tick(); #1;
    checks++;
    if ({mem_ready, mem_wr} !== 2'b10) begin failures++; $display("FAIL io_stall done got=%b exp=10", {mem_ready, mem_wr}); end
    lsb_valid = 1'b0;
    tick();
`else
    io_buffer_full = 1'b1;
    run_store(32'h0003_0000, 32'h5A, 4'h0, "io_full_ignored");
    io_buffer_full = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    run_load(32'h200, 4'h2, "lw_before_reset");
    lsb_valid = 1'b1; lsb_load_or_store = 1'b1; lsb_addr = 32'h700; lsb_data = 32'h1122_3344; lsb_op = 4'h2;
    tick(); tick();
    #3 rst_in = 1'b1;
    #1;
    checks++;
    if ({mem_ready, mem_wr, mem_val, mem_a, mem_dout} !== 74'd0) begin
      failures++; $display("FAIL reset_mid got rdy=%b wr=%b val=%h a=%h d=%h exp all 0", mem_ready, mem_wr, mem_val, mem_a, mem_dout);
    end
    lsb_valid = 1'b0;
    #1 rst_in = 1'b0;
    tick(); #1;
    checks++;
    if ({mem_ready, mem_wr} !== 2'b00) begin failures++; $display("FAIL reset_mid idle got=%b exp=00", {mem_ready, mem_wr}); end
    run_load(32'h100, 4'h4, "lbu_after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [3:0]  op;
      a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : 32'($urandom);
      op    = 4'($urandom_range(0, 2));
      op[2] = 1'($urandom_range(0, 1));
      op[3] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) run_store(a, 32'($urandom), op, "rand_store");
      else run_load(a, op, "rand_load");
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0; lsb_valid = 1'b0; lsb_load_or_store = 1'b0;
    io_buffer_full = 1'b0; lsb_addr = '0; lsb_data = '0; lsb_op = '0;
    ram[32'h100] = 8'h80; ram[32'h101] = 8'h34; ram[32'h102] = 8'hC2;
    ram[32'h200] = 8'h11; ram[32'h201] = 8'h22; ram[32'h202] = 8'h33; ram[32'h203] = 8'h44;
    test_reset();
    test_load_sign();
    test_load_word();
    test_store_wrap();
    test_clear_read();
    test_clear_write();
    test_clear_done();
    test_clear_idle();
    test_rdy_stall();
    test_io();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
